// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

    localparam int BOOTH_WIDTH = 16;
    localparam int BOOTH_CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } booth_state_t;

    // Booth pair {Q[0], Q[-1]}
    localparam logic [1:0] BOOTH_PAIR_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_PAIR_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_PAIR_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_PAIR_NOP1 = 2'b11;

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration down-counter: loads WIDTH, decrements per shift, saturates at 0.
// Latency: count updates one edge after ld/dec; zero_next is combinational.
// Backpressure: none; load has priority over decrement.
module booth_iter_cnt #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero_next
);

    localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Load to WIDTH, else decrement without wrapping below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (ld) begin
            r_count <= LP_LOAD;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - LP_ONE;
        end
    end

    assign count     = r_count;
    assign zero_next = dec && (r_count == LP_ONE);

endmodule

// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth sequencer: LOAD, then WIDTH x (EVAL, SHIFT), then a one-cycle DONE.
// Latency: DONE is 2*WIDTH+2 cycles after the edge that samples start.
// Backpressure: start is ignored while busy; held start chains DONE straight into LOAD.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH,
    parameter int CNT_W = BOOTH_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             q0,
    input  logic             qm1,
    output logic             ld,
    output logic             add_en,
    output logic             add_sub,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    booth_state_t r_state;
    booth_state_t w_state_nxt;
    logic         r_ld;
    logic         r_shift;
    logic         r_busy;
    logic         r_done;
    logic         r_eval;
    logic         w_zero_next;
    logic [1:0]   w_pair;
    logic         w_add_en;

    // Iteration counter is loaded while in LOAD and stepped while in SHIFT.
    booth_iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld        (r_ld),
        .dec       (r_shift),
        .count     (count),
        .zero_next (w_zero_next)
    );

    // Next-state decode; start only matters in IDLE and DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  w_state_nxt = ST_EVAL;
            ST_EVAL:  w_state_nxt = ST_SHIFT;
            ST_SHIFT: w_state_nxt = w_zero_next ? ST_DONE : ST_EVAL;
            ST_DONE:  w_state_nxt = start ? ST_LOAD : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register with Moore strobes registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ld    <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_eval  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ld    <= (w_state_nxt == ST_LOAD);
            r_shift <= (w_state_nxt == ST_SHIFT);
            r_eval  <= (w_state_nxt == ST_EVAL);
            r_busy  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_EVAL) ||
                       (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign w_pair = {q0, qm1};

    // Booth pair decode: 01 adds M, 10 subtracts M, 00/11 leave A alone.
    always_comb begin
        w_add_en = 1'b0;
        if (r_eval) begin
            case (w_pair)
                BOOTH_PAIR_ADD,
                BOOTH_PAIR_SUB:  w_add_en = 1'b1;
                BOOTH_PAIR_NOP0,
                BOOTH_PAIR_NOP1: w_add_en = 1'b0;
                default:         w_add_en = 1'b0;
            endcase
        end
    end

    assign ld      = r_ld;
    assign shift   = r_shift;
    assign busy    = r_busy;
    assign done    = r_done;
    assign add_en  = w_add_en;
    assign add_sub = r_eval & q0;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl paired with a behavioural Booth datapath.
// Latency checked: DONE at cycle 34 after the sampling edge for WIDTH=16.
// Backpressure checked: start ignored while busy, held start chains operations.
module tb_booth_seq_ctrl;
    import booth_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       q0;
    logic       qm1;
    logic       ld;
    logic       add_en;
    logic       add_sub;
    logic       shift;
    logic       busy;
    logic       done;
    logic [4:0] count;

    int n_cmp;
    int n_bad;

    // Behavioural datapath; A carries one extra bit so -32768 operands are exact.
    logic [15:0] op_mc;
    logic [15:0] op_mp;
    logic [16:0] A;
    logic [15:0] Q;
    logic [15:0] M;
    logic        Qm;

    logic        busy_tr [0:63];
    logic [4:0]  cnt_tr  [0:63];
    logic        prev_done;

    booth_seq_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .q0      (q0),
        .qm1     (qm1),
        .ld      (ld),
        .add_en  (add_en),
        .add_sub (add_sub),
        .shift   (shift),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign q0  = Q[0];
    assign qm1 = Qm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A <= '0; Q <= '0; M <= '0; Qm <= 1'b0;
        end else if (ld) begin
            A <= '0; Q <= op_mp; M <= op_mc; Qm <= 1'b0;
        end else if (add_en) begin
            A <= add_sub ? (A - {M[15], M}) : (A + {M[15], M});
        end else if (shift) begin
            {A, Q, Qm} <= {A[16], A, Q};
        end
    end

    // Per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if ((32'(ld) + 32'(shift) + 32'(dut.r_state == ST_EVAL)) > 1) begin
                n_bad++;
                $display("FAIL onehot_strobes: ld=%0b shift=%0b eval=%0b required at most one",
                         ld, shift, dut.r_state == ST_EVAL);
            end
            n_cmp++;
            if (prev_done && done) begin
                n_bad++;
                $display("FAIL done_width: done high 2 cycles, required 1");
            end
            n_cmp++;
            if (count > 5'd16) begin
                n_bad++;
                $display("FAIL count_range: count=%0d required <=16", count);
            end
            n_cmp++;
            if (busy && done) begin
                n_bad++;
                $display("FAIL busy_done: both high, required exclusive");
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Runs one multiply from IDLE/DONE; traces busy and count per cycle.
    task automatic do_op(input logic [15:0] mc, input logic [15:0] mp, input bit tgl,
                         output logic [31:0] prod, output int dcyc, output int nshift,
                         output int nadd, output int nsub, output int first_add);
        dcyc = 0; nshift = 0; nadd = 0; nsub = 0; first_add = 0; prod = '0;
        @(negedge clk);
        busy_tr[0] = busy;
        op_mc = mc; op_mp = mp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 64; c++) begin
            busy_tr[c] = busy;
            cnt_tr[c]  = count;
            if (shift) nshift++;
            if (add_en) begin
                nadd++;
                if (add_sub) nsub++;
                if (first_add == 0) first_add = c;
            end
            if (done) begin
                dcyc = c;
                prod = {A[15:0], Q};
                break;
            end
            start = (tgl && c >= 2 && c <= 31) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op_mc = '0; op_mp = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({ld, add_en, add_sub, shift, busy, done} !== 6'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b required 000000",
                              {ld, add_en, add_sub, shift, busy, done});
        end
        n_cmp++; if (count !== 5'd0) begin
            n_bad++; $display("FAIL reset_count: got %0d required 0", count);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (dut.r_state !== ST_IDLE || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: state=%0d busy=%0b done=%0b required IDLE,0,0",
                              dut.r_state, busy, done);
        end
    endtask

    task automatic test_basic;
        logic [31:0] p; int dc, ns, na, nsb, fa;
        do_op(16'd3, 16'hFFFB, 1'b0, p, dc, ns, na, nsb, fa);
        n_cmp++; if (busy_tr[0] !== 1'b0 || busy_tr[1] !== 1'b1) begin
            n_bad++; $display("FAIL basic_busy_rise: c0=%0b c1=%0b required 0,1",
                              busy_tr[0], busy_tr[1]);
        end
        n_cmp++; if (dc != 34) begin
            n_bad++; $display("FAIL basic_done_cycle: got %0d required 34", dc);
        end
        n_cmp++; if (p !== 32'hFFFFFFF1) begin
            n_bad++; $display("FAIL basic_product: got %h required fffffff1", p);
        end
        n_cmp++; if (ns != 16) begin
            n_bad++; $display("FAIL basic_shifts: got %0d required 16", ns);
        end
        n_cmp++; if (cnt_tr[2] !== 5'd16 || cnt_tr[33] !== 5'd1) begin
            n_bad++; $display("FAIL basic_count: c2=%0d c33=%0d required 16,1",
                              cnt_tr[2], cnt_tr[33]);
        end
        @(posedge clk); #1;
        n_cmp++; if (count !== 5'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_after_done: count=%0d busy=%0b required 0,0", count, busy);
        end
    endtask

    task automatic test_patterns;
        logic [31:0] p; int dc, ns, na, nsb, fa;
        do_op(16'h0001, 16'h5555, 1'b0, p, dc, ns, na, nsb, fa);
        n_cmp++; if (p !== 32'h00005555) begin
            n_bad++; $display("FAIL alt_product: got %h required 00005555", p);
        end
        n_cmp++; if (na != 16) begin
            n_bad++; $display("FAIL alt_add_count: got %0d required 16", na);
        end
        do_op(16'd7, 16'hFFFF, 1'b0, p, dc, ns, na, nsb, fa);
        n_cmp++; if (p !== 32'hFFFFFFF9) begin
            n_bad++; $display("FAIL ones_product: got %h required fffffff9", p);
        end
        n_cmp++; if (na != 1 || nsb != 1 || fa != 2) begin
            n_bad++; $display("FAIL ones_add: adds=%0d subs=%0d first=%0d required 1,1,2",
                              na, nsb, fa);
        end
    endtask

    task automatic test_corners;
        logic [31:0] p; int dc, ns, na, nsb, fa;
        do_op(16'h8000, 16'h8000, 1'b0, p, dc, ns, na, nsb, fa);
        n_cmp++; if (p !== 32'h40000000) begin
            n_bad++; $display("FAIL corner_minmin: got %h required 40000000", p);
        end
        do_op(16'd0, 16'd12345, 1'b0, p, dc, ns, na, nsb, fa);
        n_cmp++; if (p !== 32'h00000000) begin
            n_bad++; $display("FAIL corner_zero: got %h required 00000000", p);
        end
        do_op(16'd32767, 16'hFFFF, 1'b0, p, dc, ns, na, nsb, fa);
        n_cmp++; if (p !== 32'hFFFF8001 || dc != 34) begin
            n_bad++; $display("FAIL corner_maxneg1: got %h at %0d required ffff8001 at 34", p, dc);
        end
    endtask

    task automatic test_back_to_back;
        int nd; int dcs [0:2]; logic [31:0] prs [0:2];
        logic ld35, ld69, busy103, done103;
        nd = 0; ld35 = 0; ld69 = 0; busy103 = 1; done103 = 1;
        dcs[0] = 0; dcs[1] = 0; dcs[2] = 0; prs[0] = '0; prs[1] = '0; prs[2] = '0;
        @(negedge clk);
        op_mc = 16'd3; op_mp = 16'hFFFB; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 110; c++) begin
            if (done) begin
                if (nd < 3) begin dcs[nd] = c; prs[nd] = {A[15:0], Q}; end
                nd++;
            end
            if (c == 35) ld35 = ld;
            if (c == 69) ld69 = ld;
            if (c == 103) begin busy103 = busy; done103 = done; end
            if (c == 100) start = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++; if (nd != 3) begin
            n_bad++; $display("FAIL b2b_count: got %0d dones required 3", nd);
        end
        n_cmp++; if (dcs[0] != 34 || dcs[1] != 68 || dcs[2] != 102) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d,%0d,%0d required 34,68,102",
                              dcs[0], dcs[1], dcs[2]);
        end
        n_cmp++; if (ld35 !== 1'b1 || ld69 !== 1'b1) begin
            n_bad++; $display("FAIL b2b_no_bubble: ld35=%0b ld69=%0b required 1,1", ld35, ld69);
        end
        n_cmp++; if (prs[0] !== 32'hFFFFFFF1 || prs[1] !== 32'hFFFFFFF1 || prs[2] !== 32'hFFFFFFF1) begin
            n_bad++; $display("FAIL b2b_product: got %h %h %h required fffffff1",
                              prs[0], prs[1], prs[2]);
        end
        n_cmp++; if (busy103 !== 1'b0 || done103 !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle_after: busy=%0b done=%0b required 0,0", busy103, done103);
        end
    endtask

    task automatic test_start_ignored;
        logic [31:0] p; int dc, ns, na, nsb, fa; int bad_cnt;
        do_op(16'd3, 16'hFFFB, 1'b1, p, dc, ns, na, nsb, fa);
        n_cmp++; if (dc != 34 || p !== 32'hFFFFFFF1) begin
            n_bad++; $display("FAIL toggle_done: got cycle %0d prod %h required 34 fffffff1", dc, p);
        end
        bad_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (cnt_tr[2 + 2 * k] !== 5'(16 - k) || cnt_tr[3 + 2 * k] !== 5'(16 - k)) bad_cnt++;
        end
        n_cmp++; if (bad_cnt != 0) begin
            n_bad++; $display("FAIL toggle_count: %0d iterations with wrong count, required 0", bad_cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] p; int dc, ns, na, nsb, fa; int late_done;
        @(negedge clk);
        op_mc = 16'd5; op_mp = 16'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_cmp++; if (count !== 5'd9 || dut.r_state !== ST_EVAL) begin
            n_bad++; $display("FAIL mid_precond: count=%0d state=%0d required 9 EVAL",
                              count, dut.r_state);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({ld, add_en, add_sub, shift, busy, done} !== 6'b0 || count !== 5'd0) begin
            n_bad++; $display("FAIL mid_async: outs=%b count=%0d required 000000 0",
                              {ld, add_en, add_sub, shift, busy, done}, count);
        end
        n_cmp++; if (dut.r_state !== ST_IDLE) begin
            n_bad++; $display("FAIL mid_state: got %0d required IDLE", dut.r_state);
        end
        late_done = 0;
        repeat (3) begin @(posedge clk); #1; if (done) late_done++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done) late_done++; end
        n_cmp++; if (late_done != 0) begin
            n_bad++; $display("FAIL mid_no_done: got %0d pulses required 0", late_done);
        end
        do_op(16'd2, 16'd2, 1'b0, p, dc, ns, na, nsb, fa);
        n_cmp++; if (p !== 32'd4 || dc != 34) begin
            n_bad++; $display("FAIL mid_recover: got %h at %0d required 00000004 at 34", p, dc);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; prev_done = 1'b0;
        test_reset();
        test_basic();
        test_patterns();
        test_corners();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
